// File: rtl/tlc5940_pkg.sv
// Shared defaults and latch classification for the TLC5940-style serial receiver.
package tlc5940_pkg;

  localparam int TLC_CHANNELS = 16;
  localparam int TLC_GS_WIDTH = 12;
  localparam int TLC_DC_WIDTH = 6;

  function automatic int frame_bits(input int channels, input int width);
    return channels * width;
  endfunction

  localparam int GS_FRAME_BITS = frame_bits(TLC_CHANNELS, TLC_GS_WIDTH);
  localparam int DC_FRAME_BITS = frame_bits(TLC_CHANNELS, TLC_DC_WIDTH);

  typedef enum logic [1:0] {
    LATCH_NONE,
    LATCH_GS,
    LATCH_DC,
    LATCH_ERR
  } latch_e;

  // A latch is only honoured when exactly one full frame of the selected kind was shifted.
  function automatic latch_e latch_decode(input logic mode, input int bit_cnt,
                                          input int gs_bits, input int dc_bits);
    if (!mode && bit_cnt == gs_bits) return LATCH_GS;
    if (mode && bit_cnt == dc_bits) return LATCH_DC;
    return LATCH_ERR;
  endfunction

endpackage

// File: rtl/tlc5940_rx_edge_sync.sv
// Two-flop synchronizer with a rising-edge detector on the synchronized level.
module edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o
);

  logic [2:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[1:0], async_i};
  end

  assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/tlc5940_rx.sv
// TLC5940-style receiver: serial GS/DC frame capture, latch validation and PWM channel outputs.
module tlc5940_rx
  import tlc5940_pkg::*;
#(
  parameter int CHANNELS = TLC_CHANNELS,
  parameter int GS_WIDTH = TLC_GS_WIDTH,
  parameter int DC_WIDTH = TLC_DC_WIDTH
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                led_sclk,
  input  logic                led_sin,
  input  logic                led_mode,
  input  logic                led_xlat,
  input  logic                led_blank,
  input  logic                led_gsclk,
  output logic [CHANNELS-1:0] chan_out,
  output logic                led_xerr,
  output logic                gs_update,
  output logic                dc_update
);

  localparam int GsBits = frame_bits(CHANNELS, GS_WIDTH);
  localparam int DcBits = frame_bits(CHANNELS, DC_WIDTH);
  localparam int CntW   = $clog2(GsBits + 2);
  localparam int PwmW   = GS_WIDTH + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(GsBits + 1);
  localparam logic [PwmW-1:0] PwmMax = {1'b1, {GS_WIDTH{1'b0}}};

  logic sclk_rise, xlat_rise, gsclk_rise;
  logic [2:0] dsync1_q, dsync2_q;
  logic sin_s, mode_s, blank_s;

  logic [GsBits-1:0]   sr_q, sr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [GsBits-1:0]   gs_q, gs_d;
  logic [DcBits-1:0]   dc_q, dc_d;
  logic                xerr_q, xerr_d;
  logic                gs_upd_q, gs_upd_d;
  logic                dc_upd_q, dc_upd_d;
  logic [PwmW-1:0]     pwm_q, pwm_d;
  logic [CHANNELS-1:0] chan_q, chan_d;
  latch_e              latch;

  edge_sync u_sync_sclk  (.clk_i(clock), .rst_i(reset), .async_i(led_sclk),  .rise_o(sclk_rise));
  edge_sync u_sync_xlat  (.clk_i(clock), .rst_i(reset), .async_i(led_xlat),  .rise_o(xlat_rise));
  edge_sync u_sync_gsclk (.clk_i(clock), .rst_i(reset), .async_i(led_gsclk), .rise_o(gsclk_rise));

  assign sin_s   = dsync2_q[0];
  assign mode_s  = dsync2_q[1];
  assign blank_s = dsync2_q[2];

  // The shift is applied first so a coincident xlat sees the bit it arrived with.
  always_comb begin
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    gs_d     = gs_q;
    dc_d     = dc_q;
    xerr_d   = xerr_q;
    gs_upd_d = 1'b0;
    dc_upd_d = 1'b0;
    latch    = LATCH_NONE;
    if (sclk_rise) begin
      sr_d = {sr_q[GsBits-2:0], sin_s};
      if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
    end
    if (xlat_rise) begin
      latch = latch_decode(mode_s, int'(cnt_d), GsBits, DcBits);
      case (latch)
        LATCH_GS: begin
          gs_d     = sr_d;
          gs_upd_d = 1'b1;
          xerr_d   = 1'b1;
        end
        LATCH_DC: begin
          dc_d     = sr_d[DcBits-1:0];
          dc_upd_d = 1'b1;
          xerr_d   = 1'b1;
        end
        default: xerr_d = 1'b0;
      endcase
      cnt_d = '0;
    end
  end

  always_comb begin
    pwm_d = pwm_q;
    if (blank_s) pwm_d = '0;
    else if (gsclk_rise && pwm_q != PwmMax) pwm_d = pwm_q + 1'b1;
  end

  always_comb begin
    chan_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      chan_d[i] = !blank_s && (pwm_q != '0)
                  && (pwm_q <= {1'b0, gs_q[i*GS_WIDTH +: GS_WIDTH]})
                  && (dc_q[i*DC_WIDTH +: DC_WIDTH] != '0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dsync1_q <= '0;
      dsync2_q <= '0;
      sr_q     <= '0;
      cnt_q    <= '0;
      gs_q     <= '0;
      dc_q     <= '1;
      xerr_q   <= 1'b1;
      gs_upd_q <= 1'b0;
      dc_upd_q <= 1'b0;
      pwm_q    <= '0;
      chan_q   <= '0;
    end else begin
      dsync1_q <= {led_blank, led_mode, led_sin};
      dsync2_q <= dsync1_q;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      gs_q     <= gs_d;
      dc_q     <= dc_d;
      xerr_q   <= xerr_d;
      gs_upd_q <= gs_upd_d;
      dc_upd_q <= dc_upd_d;
      pwm_q    <= pwm_d;
      chan_q   <= chan_d;
    end
  end

  assign chan_out  = chan_q;
  assign led_xerr  = xerr_q;
  assign gs_update = gs_upd_q;
  assign dc_update = dc_upd_q;

endmodule

// File: tb/tb_tlc5940_rx.sv
// Directed bench for tlc5940_rx; latch pulses are checked against a queue of expected updates.
module tb_tlc5940_rx;

  logic        clock = 1'b0;
  logic        reset;
  logic        led_sclk, led_sin, led_mode, led_xlat, led_blank, led_gsclk;
  logic [15:0] chan_out;
  logic        led_xerr, gs_update, dc_update;

  int total = 0;
  int bad   = 0;
  logic [1:0] exp_q[$];  // {dc, gs} per expected latch pulse

  tlc5940_rx dut (
    .clock(clock), .reset(reset), .led_sclk(led_sclk), .led_sin(led_sin),
    .led_mode(led_mode), .led_xlat(led_xlat), .led_blank(led_blank),
    .led_gsclk(led_gsclk), .chan_out(chan_out), .led_xerr(led_xerr),
    .gs_update(gs_update), .dc_update(dc_update)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (gs_update || dc_update) begin
      if (exp_q.size() == 0)
        check("unexpected_update", {30'b0, dc_update, gs_update}, 32'h0);
      else
        check("update_kind", {30'b0, dc_update, gs_update}, {30'b0, exp_q.pop_front()});
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bit(input logic b);
    led_sin  = b;
    led_sclk = 1'b0;
    cyc(2);
    led_sclk = 1'b1;
    cyc(2);
  endtask

  task automatic send_bits(input logic [191:0] v, input int msb, input int n);
    for (int i = 0; i < n; i++) send_bit(v[msb-i]);
    led_sclk = 1'b0;
    cyc(2);
  endtask

  task automatic xlat_pulse();
    led_sclk = 1'b0;
    led_xlat = 1'b1;
    cyc(2);
    led_xlat = 1'b0;
    cyc(4);
  endtask

  task automatic gs_edge();
    led_gsclk = 1'b1;
    cyc(2);
    led_gsclk = 1'b0;
    cyc(2);
  endtask

  task automatic set_blank(input logic b);
    led_blank = b;
    cyc(4);
  endtask

  logic [191:0] f;

  initial begin
    reset = 1'b1; led_sclk = 1'b0; led_sin = 1'b0; led_mode = 1'b0;
    led_xlat = 1'b0; led_blank = 1'b1; led_gsclk = 1'b0;
    cyc(3);
    reset = 1'b0;
    cyc(1);
    check("reset_chan", 32'(chan_out), 32'h0);
    check("reset_xerr", 32'(led_xerr), 32'h1);
    check("reset_gs_update", 32'(gs_update), 32'h0);
    check("reset_dc_update", 32'(dc_update), 32'h0);

    // channel 0 GS=4
    f = '0; f[0 +: 12] = 12'd4;
    exp_q.push_back(2'b01);
    send_bits(f, 191, 192);
    xlat_pulse();
    check("gs4_xerr", 32'(led_xerr), 32'h1);
    set_blank(1'b0);
    check("gs4_idle", 32'(chan_out), 32'h0);
    for (int k = 1; k <= 5; k++) begin
      gs_edge();
      check("gs4_pwm", 32'(chan_out), (k <= 4) ? 32'h1 : 32'h0);
    end
    set_blank(1'b1);
    check("gs4_blank", 32'(chan_out), 32'h0);

    // short frame rejected, GS retained, then good frame clears the error
    f = '1;
    send_bits(f, 191, 191);
    xlat_pulse();
    check("short_xerr", 32'(led_xerr), 32'h0);
    set_blank(1'b0);
    gs_edge();
    check("short_gs_kept", 32'(chan_out), 32'h1);
    set_blank(1'b1);
    f = '0; f[12 +: 12] = 12'd2;
    exp_q.push_back(2'b01);
    send_bits(f, 191, 192);
    xlat_pulse();
    check("recover_xerr", 32'(led_xerr), 32'h1);
    set_blank(1'b0);
    for (int k = 1; k <= 3; k++) begin
      gs_edge();
      check("recover_pwm", 32'(chan_out), (k <= 2) ? 32'h2 : 32'h0);
    end
    set_blank(1'b1);

    // channel 3 DC=0 masks GS=4095 for a whole PWM cycle
    f = '0; f[95:0] = '1; f[18 +: 6] = 6'd0;
    led_mode = 1'b1;
    exp_q.push_back(2'b10);
    send_bits(f, 95, 96);
    xlat_pulse();
    led_mode = 1'b0;
    check("dc_xerr", 32'(led_xerr), 32'h1);
    f = '0; f[36 +: 12] = 12'hFFF; f[0 +: 12] = 12'd1;
    exp_q.push_back(2'b01);
    send_bits(f, 191, 192);
    xlat_pulse();
    set_blank(1'b0);
    for (int k = 1; k <= 4096; k++) begin
      gs_edge();
      check("dc0_cycle", 32'(chan_out), (k == 1) ? 32'h1 : 32'h0);
    end
    set_blank(1'b1);

    // all GS=4095: counter saturates at 4096, blank restarts it
    f = '0; f[95:0] = '1;
    led_mode = 1'b1;
    exp_q.push_back(2'b10);
    send_bits(f, 95, 96);
    xlat_pulse();
    led_mode = 1'b0;
    f = '1;
    exp_q.push_back(2'b01);
    send_bits(f, 191, 192);
    xlat_pulse();
    set_blank(1'b0);
    for (int k = 1; k <= 4100; k++) begin
      gs_edge();
      check("sat_pwm", 32'(chan_out), (k <= 4095) ? 32'hFFFF : 32'h0);
    end
    set_blank(1'b1);
    check("sat_blank", 32'(chan_out), 32'h0);
    set_blank(1'b0);
    check("sat_cleared_idle", 32'(chan_out), 32'h0);
    gs_edge();
    check("sat_restart", 32'(chan_out), 32'hFFFF);
    set_blank(1'b1);

    // reset mid-frame discards the partial frame
    f = '0; f[24 +: 12] = 12'd3;
    send_bits(f, 191, 100);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(2);
    exp_q.push_back(2'b01);
    send_bits(f, 191, 192);
    xlat_pulse();
    check("midreset_xerr", 32'(led_xerr), 32'h1);
    set_blank(1'b0);
    for (int k = 1; k <= 4; k++) begin
      gs_edge();
      check("midreset_pwm", 32'(chan_out), (k <= 3) ? 32'h4 : 32'h0);
    end
    set_blank(1'b1);

    // empty latch flags an error; final sclk coincident with xlat is accepted
    xlat_pulse();
    check("empty_xerr", 32'(led_xerr), 32'h0);
    f = '0; f[60 +: 12] = 12'd7;
    exp_q.push_back(2'b01);
    send_bits(f, 191, 191);
    led_sin = f[0];
    cyc(2);
    led_sclk = 1'b1;
    led_xlat = 1'b1;
    cyc(2);
    led_sclk = 1'b0;
    led_xlat = 1'b0;
    cyc(4);
    check("coincide_xerr", 32'(led_xerr), 32'h1);
    set_blank(1'b0);
    for (int k = 1; k <= 8; k++) begin
      gs_edge();
      check("coincide_pwm", 32'(chan_out), (k <= 7) ? 32'h20 : 32'h0);
    end
    set_blank(1'b1);

    cyc(4);
    check("pending_updates", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
